// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: beat counting, delay-line/butterfly strobes, twiddle addressing, drain.
// Zero-cycle latency from accepted beat to strobes; in_ready drops for the DELAY-cycle self-timed drain.
module fft_sdf_stage_ctrl #(
  parameter int DELAY       = 16,
  parameter int FRAME_BEATS = 32,
  parameter int TW_W        = $clog2(DELAY)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sr_shift_en,
  output logic            bfly_en,
  output logic            out_sel_diff,
  output logic            tw_valid,
  output logic [TW_W-1:0] tw_addr,
  output logic            out_valid,
  output logic            frame_start,
  output logic            frame_done,
  output logic            ovf_err
);

  localparam int BW = $clog2(FRAME_BEATS);
  localparam int PB = $clog2(DELAY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          fsm_q, fsm_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            primed_q, primed_d;
  logic            ovf_err_q, ovf_err_d;
  logic            phase;

  assign phase = beat_cnt_q[PB];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q       <= IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      primed_q    <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      primed_q    <= primed_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    beat_cnt_d   = beat_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    primed_d     = primed_q;
    ovf_err_d    = ovf_err_q;
    in_ready     = 1'b0;
    sr_shift_en  = 1'b0;
    bfly_en      = 1'b0;
    out_sel_diff = 1'b0;
    tw_valid     = 1'b0;
    tw_addr      = '0;
    out_valid    = 1'b0;
    frame_start  = 1'b0;
    frame_done   = 1'b0;
    ovf_err      = 1'b0;

    if (flush) begin
      fsm_d       = IDLE;
      beat_cnt_d  = '0;
      drain_cnt_d = '0;
      primed_d    = 1'b0;
      ovf_err_d   = 1'b0;
    end else begin
      ovf_err = ovf_err_q;
      case (fsm_q)
        IDLE, RUN: begin
          in_ready = 1'b1;
          if (in_valid) begin
            sr_shift_en  = 1'b1;
            bfly_en      = phase;
            out_sel_diff = ~phase;
            out_valid    = phase | primed_q;
            tw_valid     = ~phase & primed_q;
            tw_addr      = beat_cnt_q[TW_W-1:0];
            frame_start  = (fsm_q == IDLE);
            primed_d     = primed_q | phase;
            if (beat_cnt_q == BW'(FRAME_BEATS - 1)) begin
              fsm_d       = DRAIN;
              drain_cnt_d = '0;
            end else begin
              fsm_d      = RUN;
              beat_cnt_d = beat_cnt_q + BW'(1);
            end
          end
        end
        DRAIN: begin
          // Self-timed: stored differences leave one per cycle whatever in_valid does.
          sr_shift_en  = 1'b1;
          out_sel_diff = 1'b1;
          out_valid    = 1'b1;
          tw_valid     = 1'b1;
          tw_addr      = drain_cnt_q;
          drain_cnt_d  = drain_cnt_q + TW_W'(1);
          if (in_valid) begin
            ovf_err   = 1'b1;
            ovf_err_d = 1'b1;
          end
          if (drain_cnt_q == TW_W'(DELAY - 1)) begin
            frame_done  = 1'b1;
            fsm_d       = IDLE;
            beat_cnt_d  = '0;
            drain_cnt_d = '0;
            primed_d    = 1'b0;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed-vector bench for fft_sdf_stage_ctrl (DELAY=16 with 32- and 64-beat frames).
module tb_fft_sdf_stage_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush32 = 1'b0, flush64 = 1'b0;
  logic iv32 = 1'b0, iv64 = 1'b0;

  logic rdy32, sh32, bf32, sel32, twv32, ov32, fs32, fd32, ovf32;
  logic rdy64, sh64, bf64, sel64, twv64, ov64, fs64, fd64, ovf64;
  logic [3:0] ta32, ta64;
  logic [12:0] obs32, obs64;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl #(.DELAY(16), .FRAME_BEATS(32)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush32), .in_valid(iv32), .in_ready(rdy32),
    .sr_shift_en(sh32), .bfly_en(bf32), .out_sel_diff(sel32), .tw_valid(twv32),
    .tw_addr(ta32), .out_valid(ov32), .frame_start(fs32), .frame_done(fd32), .ovf_err(ovf32));

  fft_sdf_stage_ctrl #(.DELAY(16), .FRAME_BEATS(64)) u_dut64 (
    .clk(clk), .rstn(rstn), .flush(flush64), .in_valid(iv64), .in_ready(rdy64),
    .sr_shift_en(sh64), .bfly_en(bf64), .out_sel_diff(sel64), .tw_valid(twv64),
    .tw_addr(ta64), .out_valid(ov64), .frame_start(fs64), .frame_done(fd64), .ovf_err(ovf64));

  assign obs32 = {rdy32, sh32, bf32, sel32, twv32, ta32, ov32, fs32, fd32, ovf32};
  assign obs64 = {rdy64, sh64, bf64, sel64, twv64, ta64, ov64, fs64, fd64, ovf64};

  typedef struct {
    bit          iv;
    bit          fl;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] pk(bit rdy, bit sh, bit bf, bit sel, bit twv, int addr,
                                     bit ov, bit fs, bit fd, bit ovf);
    logic [3:0] a;
    a = 4'(addr);
    return {rdy, sh, bf, sel, twv, a, ov, fs, fd, ovf};
  endfunction

  // Accepted beat b of a frame with DELAY=16: primed holds after beat 16 was accepted.
  function automatic logic [12:0] beat_exp(int b, bit ovf);
    bit ph, pr;
    ph = ((b / 16) % 2) == 1;
    pr = b > 16;
    return pk(1, 1, ph, !ph, !ph && pr, b % 16, ph || pr, b == 0, 0, ovf);
  endfunction

  function automatic logic [12:0] drain_exp(int d, bit ovf);
    return pk(0, 1, 0, 1, 1, d, 1, 0, d == 15, ovf);
  endfunction

  function automatic logic [12:0] idle_exp(bit ovf);
    return pk(1, 0, 0, 0, 0, 0, 0, 0, 0, ovf);
  endfunction

  task automatic cmp(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(bit dut64, bit iv, bit fl, logic [12:0] exp, string name);
    logic [12:0] got;
    @(negedge clk);
    iv32 = dut64 ? 1'b0 : iv;
    iv64 = dut64 ? iv : 1'b0;
    flush32 = dut64 ? 1'b0 : fl;
    flush64 = dut64 ? fl : 1'b0;
    #1;
    got = dut64 ? obs64 : obs32;
    if (got[3]) ov_cnt++;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %b expected %b (rdy,sh,bf,sel,twv,addr,ov,fs,fd,ovf)",
               name, $time, got, exp);
    end
  endtask

  initial begin
    int b;
    int end_cont, end_gap;

    // Table: idle, continuous 32-beat frame, gapped 32-beat frame.
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, idle_exp(0)});
    for (int i = 0; i < 32; i++) tbl.push_back('{1, 0, beat_exp(i, 0)});
    for (int i = 0; i < 16; i++) tbl.push_back('{0, 0, drain_exp(i, 0)});
    end_cont = tbl.size();
    b = 0;
    while (b < 32) begin
      if ($urandom_range(1) == 0) tbl.push_back('{0, 0, idle_exp(0)});
      else begin
        tbl.push_back('{1, 0, beat_exp(b, 0)});
        b++;
      end
    end
    for (int i = 0; i < 16; i++) tbl.push_back('{0, 0, drain_exp(i, 0)});
    end_gap = tbl.size();
    for (int i = 0; i < 2; i++) tbl.push_back('{0, 0, idle_exp(0)});

    #1;
    cmp("reset_outputs", int'(obs32), int'(idle_exp(0)));
    cmp("reset_outputs64", int'(obs64), int'(idle_exp(0)));
    #21 rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 3 || i == end_cont) ov_cnt = 0;
      step(0, tbl[i].iv, tbl[i].fl, tbl[i].exp, "tbl");
      if (i == end_cont - 1) cmp("out_count_cont", ov_cnt, 32);
      if (i == end_gap - 1) cmp("out_count_gaps", ov_cnt, 32);
    end

    // Overrun: in_valid held through the drain, then flush.
    for (int i = 0; i < 32; i++) step(0, 1, 0, beat_exp(i, 0), "ovf_frame");
    for (int i = 0; i < 16; i++) step(0, 1, 0, drain_exp(i, 1), "ovf_drain");
    step(0, 1, 0, beat_exp(0, 1), "ovf_next_beat0");
    step(0, 1, 0, beat_exp(1, 1), "ovf_next_beat1");
    step(0, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush_cycle");
    step(0, 0, 0, idle_exp(0), "post_flush_idle");
    step(0, 1, 0, beat_exp(0, 0), "post_flush_beat0");

    // 64-beat frame: primed phase-0 beats 32..47 emit twiddled differences.
    ov_cnt = 0;
    for (int i = 0; i < 64; i++) step(1, 1, 0, beat_exp(i, 0), "f64_beat");
    for (int i = 0; i < 16; i++) step(1, 0, 0, drain_exp(i, 0), "f64_drain");
    cmp("out_count_f64", ov_cnt, 64);
    step(1, 0, 0, idle_exp(0), "f64_idle");

    // Async reset at beat 20, then a fresh frame.
    for (int i = 1; i < 20; i++) step(0, 1, 0, beat_exp(i, 0), "pre_reset");
    @(negedge clk);
    iv32 = 1'b0;
    rstn = 1'b0;
    #1;
    cmp("midframe_reset", int'(obs32), int'(idle_exp(0)));
    @(negedge clk);
    rstn = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 32; i++) step(0, 1, 0, beat_exp(i, 0), "post_reset_beat");
    for (int i = 0; i < 16; i++) step(0, 0, 0, drain_exp(i, 0), "post_reset_drain");
    cmp("out_count_post_reset", ov_cnt, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sdf_stage_ctrl.md
# fft_sdf_stage_ctrl

Sequencer for one radix-2 single-delay-feedback FFT stage built around the parallel-beat delay line, where each beat carries IN_SIZE complex samples. It counts accepted input beats and drives the delay-line shift enable and butterfly enable. It also drives the output-mux select, twiddle ROM address and output valid. After the last input beat of a frame it flushes the stored differences with a self-timed drain. One instance sits in front of every FFT stage's delay-line/butterfly pair.

## Interface
- DELAY, 16: delay-line depth in beats; power of 2, ≥2.
- FRAME_BEATS, 32: input beats per FFT frame; multiple of 2*DELAY.
- TW_W, $clog2(DELAY): twiddle address width.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear: state→IDLE, counters→0, ovf_err→0.
- in_valid  in  1  input beat present on datapath.
- in_ready  out  1  stage can accept a beat this cycle.
- sr_shift_en  out  1  delay-line shift strobe (drives delay-line din_valid).
- bfly_en  out  1  butterfly add/sub active: sum out, difference back into the delay line.
- out_sel_diff  out  1  0 = output butterfly sum; 1 = output delayed difference.
- tw_valid  out  1  twiddle multiply required on this output beat.
- tw_addr  out  TW_W  twiddle index k within the current half-group.
- out_valid  out  1  stage output beat valid.
- frame_start  out  1  pulse on the accepted beat 0 of a frame.
- frame_done  out  1  pulse on the last output beat of a frame.
- ovf_err  out  1  sticky: in_valid seen while in_ready=0.

## Operation
- Registered state: fsm (IDLE, RUN, DRAIN), beat_cnt (0..FRAME_BEATS-1), drain_cnt (0..DELAY-1), primed, ovf_err. All outputs are combinational from the registered state plus in_valid.
- accept = in_valid & in_ready. in_ready = 1 in IDLE and RUN, 0 in DRAIN.
- phase = beat_cnt[$clog2(DELAY)]. k = beat_cnt mod DELAY.
- IDLE: on accept, go to RUN with beat_cnt←1. This beat is frame beat 0, so frame_start=1.
- RUN: beat_cnt increments on accept only. Gaps (in_valid=0) freeze all counters and deassert every strobe. On accept of beat FRAME_BEATS-1, go to DRAIN with drain_cnt←0.
- Per accepted beat in IDLE/RUN:
  - sr_shift_en = 1.
  - bfly_en = phase.
  - out_sel_diff = ~phase.
  - out_valid = phase | primed.
  - tw_valid = ~phase & primed.
  - tw_addr = k.
- primed sets on the first accepted phase-1 beat and clears on leaving DRAIN.
- DRAIN: runs every cycle regardless of in_valid.
  - sr_shift_en=1, bfly_en=0, out_sel_diff=1, out_valid=1, tw_valid=1, tw_addr=drain_cnt.
  - drain_cnt increments. At drain_cnt=DELAY-1: frame_done=1, go to IDLE, beat_cnt←0.
- Output count per frame is exactly FRAME_BEATS.
- Overrun: in_valid=1 while in DRAIN drops the beat (no shift, no count) and sets ovf_err. ovf_err clears only on flush or reset.
- flush takes priority over all other events in its cycle. Outputs in that cycle are forced low.

## Timing
- Reset/flush values: fsm=IDLE, all counters 0, primed=0, ovf_err=0. Outputs: in_ready=1, tw_addr=0, every other output 0.
- Zero-cycle latency: strobes assert in the same cycle the beat is accepted.
- Butterfly latency through the stage is DELAY accepted beats. The first out_valid falls on accepted beat DELAY.
- Drain length is exactly DELAY cycles. The next frame can be accepted the cycle after frame_done.
- Async reset mid-frame aborts immediately. The delay-line contents are don't-care after reset.
- FRAME_BEATS = 2*DELAY: no primed phase-0 input beats; differences are emitted only in DRAIN.

## Test plan
- Reset then idle with in_valid=0 -> in_ready=1, all strobes 0, tw_addr=0.
- DELAY=16, FRAME_BEATS=32, continuous in_valid:
  - cycles 0–15: shift only, out_valid=0.
  - cycles 16–31: bfly_en=out_valid=1, out_sel_diff=0.
  - cycles 32–47: drain with in_ready=0, tw_addr 0..15.
  - frame_done at cycle 47; exactly 32 out_valid pulses.
- FRAME_BEATS=64, DELAY=16, continuous:
  - beats 32–47: out_valid=1, out_sel_diff=1, tw_valid=1, tw_addr 0..15.
  - drain at cycles 64–79; 64 outputs total.
- Random in_valid gaps (50%) with defaults -> strobe sequence identical to continuous case with stalls inserted; no strobes during gaps; 32 outputs.
- in_valid held high through DRAIN -> ovf_err=1 from the first drain cycle, no extra shifts, beats dropped. Next frame accepted the cycle after frame_done. flush clears ovf_err.
- rstn asserted at beat 20 of a frame -> all outputs at reset values immediately; a fresh 32-beat frame afterwards produces a normal sequence, with frame_start on its first beat.
